// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock controller and its lock synchronizer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } pll_state_e;

  // Width of the shared down-counter: wide enough for the largest phase length.
  function automatic int cnt_width(input int rst_cycles, input int lock_timeout, input int gate_delay);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (gate_delay > m) m = gate_delay;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for an asynchronous PLL lock indication.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic lock,
  output logic lock_sync
);

  logic meta_r;
  logic sync_r;

  // Metastability stage followed by the stable stage, both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= lock;
      sync_r <= meta_r;
    end
  end

  assign lock_sync = sync_r;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, then opens the output clock gate.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_FILTER  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int GATE_DELAY   = 32,
  parameter int MAX_RETRY    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           pll_lock,
  output logic                           pll_rst,
  output logic                           clkout0_gate,
  output logic                           pll_ready,
  output logic                           pll_err,
  output logic                           lock_lost,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, GATE_DELAY);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] GD_LOAD   = CW'(GATE_DELAY - 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(LOCK_FILTER);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  logic           lock_s;
  pll_state_e     state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s, cnt_dec_s;
  logic [FW-1:0]  filt_r, filt_s;
  logic [RW-1:0]  retry_r, retry_s, fail_retry_s;
  pll_state_e     fail_state_s;
  logic           pll_rst_r, gate_r, ready_r, err_r, lost_r;

  pll_lock_sync u_lock_sync (
    .clk       (clk),
    .rst       (rst),
    .lock      (pll_lock),
    .lock_sync (lock_s)
  );

  // Next state, counter loads and the outcome of a failed lock attempt.
  always_comb begin
    cnt_dec_s    = (cnt_r != CNT_ZERO) ? (cnt_r - CW'(1)) : CNT_ZERO;
    fail_state_s = (retry_r == RETRY_MAX) ? FAIL : RESET;
    fail_retry_s = (retry_r == RETRY_MAX) ? retry_r : (retry_r + RW'(1));
    state_s      = state_r;
    cnt_s        = cnt_dec_s;
    filt_s       = {FW{1'b0}};
    retry_s      = retry_r;
    if (!en) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = RESET;
          cnt_s   = RST_LOAD;
          retry_s = {RW{1'b0}};
        end
        RESET: begin
          if (cnt_r == CNT_ZERO) begin
            state_s = WAIT_LOCK;
            cnt_s   = TO_LOAD;
          end else begin
            state_s = RESET;
          end
        end
        WAIT_LOCK: begin
          // Qualification is checked before the timeout so it wins a tie.
          if (filt_r == FILT_MAX) begin
            state_s = SETTLE;
            cnt_s   = GD_LOAD;
          end else if (cnt_r == CNT_ZERO) begin
            state_s = fail_state_s;
            retry_s = fail_retry_s;
            cnt_s   = RST_LOAD;
          end else begin
            filt_s = lock_s ? (filt_r + FW'(1)) : {FW{1'b0}};
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state_s = fail_state_s;
            retry_s = fail_retry_s;
            cnt_s   = RST_LOAD;
          end else if (cnt_r == CNT_ZERO) begin
            state_s = RUN;
            retry_s = {RW{1'b0}};
          end else begin
            state_s = SETTLE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_s = RESET;
            cnt_s   = RST_LOAD;
          end else begin
            state_s = RUN;
          end
        end
        FAIL: begin
          state_s = FAIL;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counters and outputs decoded from the next state so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      filt_r    <= {FW{1'b0}};
      retry_r   <= {RW{1'b0}};
      pll_rst_r <= 1'b1;
      gate_r    <= 1'b0;
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      lost_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      filt_r    <= filt_s;
      retry_r   <= retry_s;
      pll_rst_r <= (state_s == IDLE) || (state_s == RESET) || (state_s == FAIL);
      gate_r    <= (state_s == RUN);
      ready_r   <= (state_s == RUN);
      err_r     <= (state_s == FAIL);
      lost_r    <= (state_r == RUN) && (state_s == RESET);
    end
  end

  assign pll_rst      = pll_rst_r;
  assign clkout0_gate = gate_r;
  assign pll_ready    = ready_r;
  assign pll_err      = err_r;
  assign lock_lost    = lost_r;
  assign retry_cnt    = retry_r;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: vector table, directed corner sequences, and random lock traffic vs a model.
module tb_pll_lock_ctrl;

  localparam int RST_C = 4;
  localparam int LF    = 3;
  localparam int GD    = 2;
  localparam int TO    = 20;
  localparam int MAXR  = 2;

  localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_SETTLE = 3, P_RUN = 4, P_FAIL = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_rst, clkout0_gate, pll_ready, pll_err, lock_lost;
  logic [1:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  pll_lock_ctrl #(
    .RST_CYCLES(RST_C), .LOCK_FILTER(LF), .LOCK_TIMEOUT(TO), .GATE_DELAY(GD), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .clkout0_gate(clkout0_gate), .pll_ready(pll_ready),
    .pll_err(pll_err), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus time spent in it, lock run length, and a two-sample lock delay line.
  typedef struct {
    int phase; int age; int run; int retry;
    bit s1; bit s2;
    bit exp_rst; bit exp_gate; bit exp_ready; bit exp_err; bit exp_lost;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.phase = P_IDLE; r.age = 0; r.run = 0; r.retry = 0; r.s1 = 1'b0; r.s2 = 1'b0;
    r.exp_rst = 1'b1; r.exp_gate = 1'b0; r.exp_ready = 1'b0; r.exp_err = 1'b0; r.exp_lost = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t c, input logic r, input logic e, input logic l);
    mdl_t n;
    bit   ls, failed, lost;
    int   nxt, spent;
    if (r) return mdl_reset();
    n = c; ls = c.s2; n.s2 = c.s1; n.s1 = l;
    nxt = c.phase; spent = c.age + 1; failed = 1'b0; lost = 1'b0;
    if (!e) nxt = P_IDLE;
    else begin
      case (c.phase)
        P_IDLE:   begin nxt = P_RESET; n.retry = 0; end
        P_RESET:  if (spent >= RST_C) nxt = P_WAIT;
        P_WAIT:   if (c.run >= LF) nxt = P_SETTLE; else if (spent >= TO) failed = 1'b1;
        P_SETTLE: if (!ls) failed = 1'b1; else if (spent >= GD) nxt = P_RUN;
        P_RUN:    if (!ls) begin nxt = P_RESET; lost = 1'b1; end
        default:  nxt = c.phase;
      endcase
    end
    if (failed) begin
      if (c.retry == MAXR) nxt = P_FAIL;
      else begin n.retry = c.retry + 1; nxt = P_RESET; end
    end
    if (nxt == P_RUN && c.phase != P_RUN) n.retry = 0;
    n.run = (c.phase == P_WAIT && nxt == P_WAIT && ls) ? c.run + 1 : 0;
    n.age = (nxt != c.phase) ? 0 : spent;
    n.phase = nxt;
    n.exp_rst   = (nxt == P_IDLE) || (nxt == P_RESET) || (nxt == P_FAIL);
    n.exp_gate  = (nxt == P_RUN);
    n.exp_ready = (nxt == P_RUN);
    n.exp_err   = (nxt == P_FAIL);
    n.exp_lost  = lost;
    return n;
  endfunction

  mdl_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits until pll_ready (which==0) or pll_err (which==1) is high; returns cycles taken.
  task automatic wait_for(input int which, input int budget, output int n);
    n = 0;
    while (((which == 0) ? pll_ready : pll_err) !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    m = mdl_reset();
    forever begin
      @(posedge clk);
      m = mdl_step(m, rst, en, pll_lock);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("mdl_pll_rst", pll_rst, m.exp_rst);
        check("mdl_gate", clkout0_gate, m.exp_gate);
        check("mdl_ready", pll_ready, m.exp_ready);
        check("mdl_err", pll_err, m.exp_err);
        check("mdl_lock_lost", lock_lost, m.exp_lost);
        check("mdl_retry", retry_cnt, m.retry);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic en; logic lock; int hold;
    logic exp_rst; logic exp_gate; logic exp_ready; int exp_retry;
    string name;
  } vec_t;

  vec_t vecs[$];
  int   n;
  int   burst;
  int   mode;

  initial begin
    // Nominal bring-up: 4 reset cycles, lock edge k at the 10th edge, gate at k+7.
    vecs.push_back('{1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0, "idle"});
    vecs.push_back('{1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 0, "reset_hold"});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0, "reset_release"});
    vecs.push_back('{1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 0, "wait_nolock"});
    vecs.push_back('{1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0, 0, "filter_settle"});
    vecs.push_back('{1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 0, "gate_k6"});
    vecs.push_back('{1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 0, "gate_k7"});

    tick(2);
    check("reset_pll_rst", pll_rst, 1'b1);
    check("reset_gate", clkout0_gate, 1'b0);
    check("reset_ready", pll_ready, 1'b0);
    check("reset_err", pll_err, 1'b0);
    check("reset_lost", lock_lost, 1'b0);
    check("reset_retry", retry_cnt, 2'd0);
    rst = 1'b0;
    checking = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en;
      pll_lock = vecs[i].lock;
      tick(vecs[i].hold);
      check({vecs[i].name, "_pll_rst"}, pll_rst, vecs[i].exp_rst);
      check({vecs[i].name, "_gate"}, clkout0_gate, vecs[i].exp_gate);
      check({vecs[i].name, "_ready"}, pll_ready, vecs[i].exp_ready);
      check({vecs[i].name, "_retry"}, retry_cnt, vecs[i].exp_retry);
    end

    // Single-cycle lock drop in RUN.
    pll_lock = 1'b0; tick(1);
    check("drop_e1_gate", clkout0_gate, 1'b1);
    pll_lock = 1'b1; tick(1);
    check("drop_e2_lost", lock_lost, 1'b0);
    tick(1);
    check("drop_lost", lock_lost, 1'b1);
    check("drop_gate", clkout0_gate, 1'b0);
    check("drop_ready", pll_ready, 1'b0);
    check("drop_pll_rst", pll_rst, 1'b1);
    check("drop_retry", retry_cnt, 2'd0);
    tick(1);
    check("drop_lost_end", lock_lost, 1'b0);
    wait_for(0, 30, n);
    check("relock_cycles", n, 9);
    check("relock_retry", retry_cnt, 2'd0);

    // Toggling lock never qualifies; timeout triggers a retry.
    en = 1'b0; tick(1);
    en = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      pll_lock = ((i % 2) == 1);
      tick(1);
      if (i == 24) begin
        check("toggle_pre_retry", retry_cnt, 2'd0);
        check("toggle_pre_rst", pll_rst, 1'b0);
      end
      if (i == 25) begin
        check("toggle_retry", retry_cnt, 2'd1);
        check("toggle_rst_on", pll_rst, 1'b1);
      end
      if (i == 28) check("toggle_rst_hold", pll_rst, 1'b1);
      if (i == 29) check("toggle_rst_off", pll_rst, 1'b0);
    end

    // No lock at all: three attempts, then FAIL.
    en = 1'b0; pll_lock = 1'b0; tick(1);
    en = 1'b1;
    wait_for(1, 100, n);
    check("fail_cycles", n, 73);
    check("fail_pll_rst", pll_rst, 1'b1);
    check("fail_retry", retry_cnt, 2'd2);
    check("fail_gate", clkout0_gate, 1'b0);
    en = 1'b0; tick(1);
    check("fail_clear_err", pll_err, 1'b0);
    check("fail_clear_rst", pll_rst, 1'b1);

    // en drops while in SETTLE.
    en = 1'b1; pll_lock = 1'b1; tick(9);
    check("settle_gate", clkout0_gate, 1'b0);
    en = 1'b0; tick(1);
    check("settle_abort_rst", pll_rst, 1'b1);
    check("settle_abort_gate", clkout0_gate, 1'b0);
    en = 1'b1; tick(4);
    check("restart_rst_hold", pll_rst, 1'b1);
    tick(1);
    check("restart_rst_off", pll_rst, 1'b0);

    // Reset while running.
    wait_for(0, 40, n);
    check("run_before_rst", pll_ready, 1'b1);
    rst = 1'b1; tick(1);
    check("rst_run_pll_rst", pll_rst, 1'b1);
    check("rst_run_gate", clkout0_gate, 1'b0);
    check("rst_run_ready", pll_ready, 1'b0);
    check("rst_run_err", pll_err, 1'b0);
    check("rst_run_retry", retry_cnt, 2'd0);
    rst = 1'b0;
    wait_for(0, 40, n);
    check("rst_rerun_cycles", n, 11);

    // Random lock traffic against the model.
    burst = 0; mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0) begin
        mode  = $urandom_range(0, 3);
        burst = $urandom_range(1, 80);
      end
      case (mode)
        0: pll_lock = 1'b1;
        1: pll_lock = 1'b0;
        2: pll_lock = ~pll_lock;
        default: pll_lock = ($urandom_range(0, 9) != 0);
      endcase
      en  = ($urandom_range(0, 99) != 0);
      rst = ($urandom_range(0, 499) == 0);
      burst--;
      tick(1);
    end
    rst = 1'b0;
    tick(2);
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
